// File: rtl/rv32i_pkg.sv
// RV32I opcode and funct3 encodings shared by the load/store path, plus
// helpers that classify a request and detect accesses that cannot be performed.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        KIND_LOAD,
        KIND_STORE,
        KIND_PASS
    } op_kind_e;

    function automatic op_kind_e op_kind(input logic [6:0] opcode);
        if (opcode == OPC_LOAD)
            return KIND_LOAD;
        else if (opcode == OPC_STORE)
            return KIND_STORE;
        else
            return KIND_PASS;
    endfunction

    // Undefined funct3 encodings are folded into the misaligned path.
    function automatic logic access_bad(input op_kind_e kind, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (kind == KIND_LOAD) begin
            case (funct3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = addr_lo[0];
                F3_W:        bad = (addr_lo != 2'b00);
                default:     bad = 1'b1;
            endcase
        end else if (kind == KIND_STORE) begin
            case (funct3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = addr_lo[0];
                F3_W:    bad = (addr_lo != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension
// for loads. Purely combinational; assumes the access is already known aligned.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'h0;
            end
        endcase
    end

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with a local data memory and a
// programmable access delay; non-memory instructions pass their ALU value through.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory access in progress, wait counter running
// RESP   | response presented, held until write-back accepts it
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_ir,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] resp_ir,
    output logic        resp_misalign
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q;
    logic [31:0]    ir_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    data_q;
    logic           misalign_q;

    logic [31:0]    mem [DEPTH];

    logic           accept;
    op_kind_e       req_kind;
    logic           req_bad;
    logic           req_direct;
    op_kind_e       cap_kind;
    logic           done;
    logic           mem_we;
    logic [AW-1:0]  idx;
    logic [31:0]    rdata;
    logic [3:0]     be;
    logic [31:0]    wdata_lane;
    logic [31:0]    load_data;

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_data     = data_q;
    assign resp_ir       = ir_q;
    assign resp_misalign = misalign_q;

    assign accept     = req_valid & req_ready;
    assign req_kind   = op_kind(req_ir[6:0]);
    assign req_bad    = access_bad(req_kind, req_ir[14:12], req_addr[1:0]);
    assign req_direct = req_bad | (req_kind == KIND_PASS);

    assign cap_kind = op_kind(ir_q[6:0]);
    assign done     = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign mem_we   = done && (cap_kind == KIND_STORE);
    assign idx      = addr_q[AW+1:2];
    assign rdata    = mem[idx];

    lsu_align u_align (
        .funct3     (ir_q[14:12]),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_direct ? S_RESP : S_ACCESS;
            S_ACCESS: if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 4'd0;
            ir_q       <= 32'h0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            data_q     <= 32'h0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            ir_q       <= req_ir;
            addr_q     <= req_addr[AW+1:0];
            wdata_q    <= req_wdata;
            cnt_q      <= WAIT_INIT;
            misalign_q <= req_bad;
            if (req_bad)
                data_q <= 32'h0;
            else if (req_kind == KIND_PASS)
                data_q <= req_addr;
        end else if (state_q == S_ACCESS) begin
            if (cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            else
                data_q <= (cap_kind == KIND_LOAD) ? load_data : 32'h0;
        end
    end

    // Memory is deliberately outside the reset domain; an aborted store never reaches mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DEPTH, 1024, data-memory size in 32-bit words (power of two).
REQ-002 Parameter: WAIT_CYCLES, 1, extra access cycles before a response (0..15).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: req_valid  input  1  request from the execute stage.
REQ-006 Port: req_ready  output  1  unit can accept a request.
REQ-007 Port: req_ir  input  32  instruction; opcode [6:0], funct3 [14:12].
REQ-008 Port: req_addr  input  32  execute ALU result (effective address, or passthrough value).
REQ-009 Port: req_wdata  input  32  rs2 value for stores.
REQ-010 Port: resp_valid  output  1  response to write-back is valid.
REQ-011 Port: resp_ready  input  1  write-back accepts the response.
REQ-012 Port: resp_data  output  32  load result, or passthrough value.
REQ-013 Port: resp_ir  output  32  instruction of the response.
REQ-014 Port: resp_misalign  output  1  access was misaligned; not performed.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-016 Handshake: request accepted on a clock edge with req_valid=1 and req_ready=1; req_ir, req_addr and req_wdata are captured into internal registers at that edge.
REQ-017 IDLE -> ACCESS on accept; a wait counter is loaded with WAIT_CYCLES.
REQ-018 ACCESS: counter decrements each cycle; at zero the access completes and the FSM goes to RESP on the next edge (total request-to-resp_valid latency = WAIT_CYCLES+1 cycles).
REQ-019 RESP: resp_valid=1; resp_data, resp_ir and resp_misalign are held stable until resp_ready=1; FSM -> IDLE on that edge.
REQ-020 The response and the next request never share a cycle (no back-to-back overlap).
REQ-021 Loads (opcode 0000011): funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half lane is selected by addr[1:0] and sign- or zero-extended to 32 bits.
REQ-022 Stores (opcode 0100011): funct3 000 SB, 001 SH, 010 SW; byte enables are derived from addr[1:0]; only enabled lanes are written, at ACCESS completion; resp_data=0.
REQ-023 Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored (wrap-around).
REQ-024 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=00 -> resp_misalign=1, no memory write, resp_data=0, FSM skips ACCESS (IDLE -> RESP, latency 1).
REQ-025 Undefined load/store funct3 values are treated as a misaligned access (resp_misalign=1, nothing written).
REQ-026 Any other opcode: passthrough; resp_data=captured req_addr; no memory access; latency 1 (IDLE -> RESP).
REQ-027 Memory reads are synchronous, sampled at ACCESS completion; memory contents are not cleared by reset.

Reset
REQ-028 When rst=0: FSM -> IDLE immediately; wait counter=0; req_ready=1; resp_valid=0; resp_data=0; resp_ir=0; resp_misalign=0.
REQ-029 A reset asserted during ACCESS aborts the pending store with no write; memory contents are otherwise retained.
REQ-030 The first request is accepted on the first rising edge after rst returns high.

Structure
REQ-031 Opcode constants (LOAD, STORE) and the funct3 encodings belong in a shared package rv32i_pkg; the FSM state encoding is local to this module.
REQ-032 One sub-module, lsu_align: combinational byte-enable/write-data lane shifting plus load extraction/extension, instantiated once.

Verification
REQ-033 SW 0xDEADBEEF to 0x10, then LW 0x10 -> resp_data=0xDEADBEEF, resp_misalign=0, latency WAIT_CYCLES+1.
REQ-034 After REQ-033, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-035 SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-036 LW 0x12 or SH 0x11 -> resp_misalign=1 one cycle after accept; a following LW 0x10 shows the word unchanged.
REQ-037 ADD instruction (opcode 0110011) with req_addr=0x1234 -> resp_data=0x1234 after 1 cycle; with resp_ready held 0 for 3 cycles, outputs stay stable and req_ready stays 0.
REQ-038 Assert rst=0 mid-ACCESS of SW 0xA5A5A5A5 to 0x20 (WAIT_CYCLES=3) -> outputs take reset values immediately; a later LW 0x20 returns the old value.
